// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing a FIFO write port among NUM_REQ producers.
// One owner at a time writes a burst of up to MAX_BURST words. Every write is
// gated by wfull. On release the arbiter re-arbitrates in the same cycle, so
// there is no idle bubble between back-to-back grants.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          wfull,
    output logic                          wen,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          word_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OWN  = 1'b1;

    logic [0:0]         state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   nxt_ptr;
    logic [IDX_W-1:0]   start;
    logic [IDX_W-1:0]   win;
    logic [NUM_REQ-1:0] win_oh;
    logic [BW-1:0]      burst_cnt;
    logic               found;
    logic               own_req;
    logic               rel;

    assign busy    = (state == OWN);
    assign own_req = req[owner];
    assign wen     = busy & own_req & ~wfull;
    assign wdata   = busy ? req_data[owner*DATA_WIDTH +: DATA_WIDTH] : '0;

    // Pointer one past the owner; becomes rr_ptr on release.
    assign nxt_ptr = (owner == LAST_IDX) ? '0 : owner + 1'b1;

    // While idle search from rr_ptr; during a release search from owner+1,
    // which is the value rr_ptr is about to take.
    assign start = busy ? nxt_ptr : rr_ptr;

    // Release on the last beat of a burst, or when the owner drops its request.
    assign rel = busy & ((wen & (burst_cnt == LAST_BEAT)) | ~own_req);

    assign win_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;

    // Only the owner can be acked, and only on a real write.
    always_comb begin
        ack        = '0;
        ack[owner] = wen;
    end

    // Round-robin search: first set req bit at or after start, wrapping.
    always_comb begin : arb
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(start) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    // Grant FSM: take a winner from idle or on release, else count burst beats.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state     <= IDLE;
            owner     <= '0;
            gnt       <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else if (!busy || rel) begin
            if (rel)
                rr_ptr <= nxt_ptr;
            burst_cnt <= '0;
            if (found) begin
                state <= OWN;
                owner <= win;
                gnt   <= win_oh;
            end else begin
                state <= IDLE;
                gnt   <= '0;
            end
        end else if (wen) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    // Running count of words written; wraps naturally.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n)
            word_cnt <= '0;
        else if (wen)
            word_cnt <= word_cnt + 1'b1;
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: expected writes are queued as each
// scenario is set up and popped whenever the DUT asserts wen.
module tb_fifo_write_arbiter;

    logic        wclk;
    logic        wrst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        wfull;
    logic [3:0]  ack, gnt;
    logic        wen, busy;
    logic [7:0]  wdata;
    logic [15:0] word_cnt;
    logic [3:0]  ack_s, gnt_s;
    logic        wen_s, busy_s;
    logic [7:0]  wdata_s;
    logic [3:0]  word_cnt_s;

    fifo_write_arbiter dut (
        .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data),
        .ack(ack), .gnt(gnt), .wfull(wfull), .wen(wen), .wdata(wdata),
        .busy(busy), .word_cnt(word_cnt)
    );

    // Narrow-counter copy used only to observe word_cnt wrap.
    fifo_write_arbiter #(.CNT_WIDTH(4)) dut_s (
        .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data),
        .ack(ack_s), .gnt(gnt_s), .wfull(wfull), .wen(wen_s), .wdata(wdata_s),
        .busy(busy_s), .word_cnt(word_cnt_s)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         rem[4];
    logic [7:0] base[4];
    logic [7:0] cnt[4];
    int         n_chk = 0;
    int         n_err = 0;
    int         wr_total = 0;
    int         nw;
    logic       seen_wen;
    logic [3:0] seen_gnt;

    // Producers: request while words remain, present base+count until acked.
    always_comb begin
        req      = '0;
        req_data = '0;
        for (int i = 0; i < 4; i++) begin
            req[i]            = (rem[i] != 0);
            req_data[i*8 +: 8] = base[i] + cnt[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input int idx, input int first, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.idx  = idx;
            e.data = 8'(first + k);
            sb.push_back(e);
        end
    endtask

    // One cycle: sample at negedge, score any write, advance producers after posedge.
    task automatic tick();
        exp_t e;
        int   widx;
        widx = 0;
        @(negedge wclk);
        seen_wen = wen;
        seen_gnt = gnt;
        if (wen) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wdata", 32'(wdata), 32'(e.data));
                chk("ack", 32'(ack), 32'(1 << e.idx));
                chk("gnt_on_write", 32'(gnt), 32'(1 << e.idx));
            end
            for (int i = 0; i < 4; i++)
                if (ack[i]) widx = i;
            wr_total++;
        end
        @(posedge wclk);
        #1;
        if (seen_wen) begin
            cnt[widx]++;
            rem[widx]--;
        end
    endtask

    task automatic clear_prod();
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0;
            cnt[i] = 8'h00;
        end
    endtask

    initial begin
        int guard;
        wrst_n = 1'b0;
        wfull  = 1'b0;
        clear_prod();
        for (int i = 0; i < 4; i++) begin
            rem[i]  = 1;
            base[i] = 8'h00;
        end

        // Reset held with all requests high
        #12;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wcnt", 32'(word_cnt), 32'd0);
        clear_prod();
        #1 wrst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_gnt", 32'(seen_gnt), 32'd0);
            chk("idle_wen", 32'(seen_wen), 32'd0);
        end

        // Single requester, continuous 16 words
        base[0] = 8'h00;
        push(0, 8'h00, 16);
        rem[0] = 16;
        tick();
        chk("t2_latency_gnt", 32'(seen_gnt), 32'd0);
        nw = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (c == 0) chk("t2_first_gnt", 32'(seen_gnt), 32'b0001);
            if (seen_wen) nw++;
        end
        chk("t2_wens", 32'(nw), 32'd16);
        chk("t2_wcnt", 32'(word_cnt), 32'd16);
        chk("t2_wcnt_small", 32'(word_cnt_s), 32'd0);
        tick();
        chk("t2_idle_gnt", 32'(gnt), 32'd0);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Four requesters, round robin from index 0
        wrst_n = 1'b0;
        #2 wrst_n = 1'b1;
        wr_total = 0;
        clear_prod();
        base[0] = 8'h10; base[1] = 8'h20; base[2] = 8'h30; base[3] = 8'h40;
        push(0, 8'h10, 4); push(1, 8'h20, 4); push(2, 8'h30, 4);
        push(3, 8'h40, 4); push(0, 8'h14, 4);
        rem[0] = 8; rem[1] = 4; rem[2] = 4; rem[3] = 4;
        tick();
        nw = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (seen_wen) nw++;
            if (c == 16) chk("wrap17_small", 32'(word_cnt_s), 32'd1);
        end
        chk("t3_wens_no_gap", 32'(nw), 32'd20);
        chk("t3_wcnt", 32'(word_cnt), 32'd20);
        chk("t3_wcnt_small", 32'(word_cnt_s), 32'd4);
        tick();
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);

        // wfull stall in the middle of owner 2's burst
        clear_prod();
        base[2] = 8'h50; base[3] = 8'h60;
        push(2, 8'h50, 4); push(3, 8'h60, 2);
        rem[2] = 4; rem[3] = 2;
        guard = 0;
        while (cnt[2] != 8'd2 && guard < 20) begin
            tick();
            guard++;
        end
        chk("t4_reach_2words", 32'(cnt[2]), 32'd2);
        wfull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t4_stall_wen", 32'(seen_wen), 32'd0);
            chk("t4_stall_gnt", 32'(seen_gnt), 32'b0100);
        end
        wfull = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);
        chk("t4_wcnt", 32'(word_cnt), 32'd26);
        chk("t4_idle_gnt", 32'(gnt), 32'd0);

        // Early drop by owner 1 with requester 3 waiting
        clear_prod();
        base[1] = 8'h70; base[3] = 8'h80;
        push(1, 8'h70, 2); push(3, 8'h80, 4);
        rem[1] = 2; rem[3] = 4;
        tick();
        tick();
        tick();
        tick();
        chk("t5_drop_wen", 32'(seen_wen), 32'd0);
        chk("t5_drop_gnt", 32'(seen_gnt), 32'b0010);
        tick();
        chk("t5_next_wen", 32'(seen_wen), 32'd1);
        chk("t5_next_gnt", 32'(seen_gnt), 32'b1000);
        for (int c = 0; c < 5; c++) tick();
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);
        chk("t5_wcnt", 32'(word_cnt), 32'd32);
        chk("t5_wcnt_small", 32'(word_cnt_s), 32'd0);

        // Async reset during owner 3's second word
        clear_prod();
        base[3] = 8'h90; base[0] = 8'hA0;
        push(3, 8'h90, 1);
        rem[3] = 4;
        tick();
        tick();
        #1;
        chk("t6_pre_wen", 32'(wen), 32'd1);
        wrst_n = 1'b0;
        #1;
        chk("t6_rst_gnt", 32'(gnt), 32'd0);
        chk("t6_rst_wen", 32'(wen), 32'd0);
        chk("t6_rst_ack", 32'(ack), 32'd0);
        chk("t6_rst_wcnt", 32'(word_cnt), 32'd0);
        rem[0] = 1;
        @(posedge wclk);
        #1 wrst_n = 1'b1;
        push(0, 8'hA0, 1); push(3, 8'h91, 3);
        tick();
        chk("t6_latency_gnt", 32'(seen_gnt), 32'd0);
        tick();
        chk("t6_first_gnt", 32'(seen_gnt), 32'b0001);
        for (int c = 0; c < 5; c++) tick();
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);
        chk("t6_wcnt", 32'(word_cnt), 32'd4);
        chk("t6_idle_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin write-port arbiter that shares the async FIFO write side (wen/wdata/wfull) between NUM_REQ producers in the write clock domain.
- Grants one requester at a time for a burst of up to MAX_BURST words.
- Gates every write with wfull, so the FIFO is never written while full.
- Sits between the producer blocks and Main_module's write port.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 8, word width; must match FIFO wdata.
- MAX_BURST, 4, maximum words per grant (>=1).
- CNT_WIDTH, 16, width of the written-word statistics counter.

Ports:
- wclk  input  1  write-domain clock; all logic on rising edge.
- wrst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester write request; held high while the requester has a word ready.
- req_data  input  NUM_REQ*DATA_WIDTH  requester i's word is in slice [i*DATA_WIDTH +: DATA_WIDTH]; held stable until acked.
- ack  output  NUM_REQ  one-hot; ack[i]=1 means requester i's word is written this cycle.
- gnt  output  NUM_REQ  registered one-hot current owner; all zero when idle.
- wfull  input  1  FIFO full flag, already in the wclk domain.
- wen  output  1  FIFO write enable.
- wdata  output  DATA_WIDTH  FIFO write data.
- busy  output  1  high while a grant is held (state OWN).
- word_cnt  output  CNT_WIDTH  total words written since reset; wraps from all-ones to 0.

Behaviour:
- Reset (asynchronous, takes effect immediately when wrst_n low):
  - State IDLE, gnt=0, rr_ptr=0, burst_cnt=0, word_cnt=0.
  - wen=0, ack=0, busy=0, wdata=0.
- States:
  - IDLE: no grant.
  - OWN: gnt holds the owner index.
- Arbitration function: search req starting at index rr_ptr, wrapping modulo NUM_REQ. The first set bit wins.
- IDLE -> OWN: when any req is high, the winner is registered into gnt on the next edge; burst_cnt=0. Arbitration latency is 1 cycle from req to gnt.
- OWN datapath (combinational from the registered owner):
  - wen = req[owner] & ~wfull.
  - wdata = owner's slice.
  - ack[owner] = wen; all other ack bits are 0.
- Write counting: each wen cycle increments burst_cnt and word_cnt.
- wfull high: wen=0 and ack=0. State, gnt and burst_cnt are held. There is no timeout; writing resumes the cycle wfull falls.
- Release condition, either of:
  - (a) wen high and burst_cnt==MAX_BURST-1 (last word of the burst).
  - (b) req[owner]==0 (early drop; no write occurs that cycle).
- Release cycle actions:
  - rr_ptr = (owner+1) mod NUM_REQ.
  - Re-arbitrate in the same cycle on the current req vector, searching from owner+1.
  - If there is a winner: next gnt = winner and burst_cnt=0. The previous owner may be re-selected, at lowest priority. There is no idle bubble.
  - If there is no winner: go to IDLE and gnt=0.
- A single continuous requester therefore writes every cycle with no gap (gnt stays set, burst_cnt restarts).
- A requester's req changing while it is not the owner has no effect until arbitration.
- Async reset mid-burst: gnt, wen and ack drop immediately. Words already acked are in the FIFO; the next word is not written. Arbitration restarts from index 0 after release.
- Widths:
  - burst_cnt is clog2(MAX_BURST) bits (minimum 1).
  - rr_ptr is clog2(NUM_REQ) bits.
  - word_cnt wraps modulo 2^CNT_WIDTH.

Test Plan:
1. Reset:
   - Hold wrst_n=0 with req=4'b1111 -> gnt=0, wen=0, ack=0, busy=0, word_cnt=0.
   - Release wrst_n with req=0 -> outputs stay 0 for 10 cycles.
2. Single requester (req=4'b0001, data 0x00,0x01,... advanced on each ack):
   - gnt=4'b0001 one cycle after req.
   - wen high every cycle after that; wdata sequence 0x00..0x0F over 16 cycles.
   - word_cnt=16.
3. Four requesters continuously (data tags 0x1n, 0x2n, 0x3n, 0x4n) -> gnt order 0001, 0010, 0100, 1000, 0001, each holding for exactly 4 wen cycles with no idle cycle between grants.
4. wfull stall:
   - Raise wfull for 5 cycles after owner 2 writes 2 words -> wen=0 and gnt=4'b0100 held.
   - After wfull falls, exactly 2 more words are written, then gnt moves to 3.
5. Early drop:
   - req[1] falls after 2 words, with req[3] high -> no write in the drop cycle.
   - Next gnt=4'b1000 with no idle cycle; word_cnt reflects only written words.
6. Reset mid-burst and counter wrap:
   - Pulse wrst_n low during owner 3's second word -> gnt and wen=0 immediately.
   - After release with req=4'b1001 -> gnt=4'b0001 first.
   - Separately, with CNT_WIDTH=4, 17 writes -> word_cnt=1.
